// File: rtl/writeback_regfile.sv
// Write-back stage and 32-entry MIPS general-purpose register file, with two
// combinational decode read ports, a registered debug port and a retired-write counter.
// Optional macro WB_BYPASS_EN adds write-through from the write-back value to the read ports.
module writeback_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              MemToReg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] MemData,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] DebugRegister,
    output logic [DATA_W-1:0] DebugData,
    output logic [CNT_W-1:0]  WriteCount
);

    localparam int unsigned NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] debug_q, debug_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_c;

    // $0 is never a commit target, so it never counts as a retired write
    assign WriteData = MemToReg ? MemData : ALUResult;
    assign we_c      = RegWrite && (WriteRegister != '0);

    always_comb begin
        count_d = count_q;
        debug_d = (DebugRegister == '0) ? '0 : regs_q[DebugRegister];
        if (we_c) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
            debug_q <= '0;
            count_q <= '0;
        end else begin
            if (we_c) begin
                regs_q[WriteRegister] <= WriteData;
            end
            debug_q <= debug_d;
            count_q <= count_d;
        end
    end

    // Index 0 always reads as zero; the write-through never fires during reset
    always_comb begin
        ReadData1 = (ReadRegister1 == '0) ? '0 : regs_q[ReadRegister1];
        ReadData2 = (ReadRegister2 == '0) ? '0 : regs_q[ReadRegister2];
`ifdef WB_BYPASS_EN
        if (!Rst && we_c && (WriteRegister == ReadRegister1)) begin
            ReadData1 = WriteData;
        end
        if (!Rst && we_c && (WriteRegister == ReadRegister2)) begin
            ReadData2 = WriteData;
        end
`endif
    end

    assign DebugData  = debug_q;
    assign WriteCount = count_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed self-checking bench for writeback_regfile: vector table plus hand sequences
// for hazard, debug latency, reset-vs-write and counter wrap (second instance with CNT_W=4).
module tb_writeback_regfile;

    logic        clk;
    logic        rst;
    logic        mem_to_reg;
    logic        reg_write;
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [4:0]  write_reg;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  debug_reg;
    logic [31:0] rd1, rd2, wdata, dbg;
    logic [31:0] wcount;
    logic [31:0] rd1_s, rd2_s, wdata_s, dbg_s;
    logic [3:0]  wcount_s;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_m    = 0;

    writeback_regfile dut (
        .Clk(clk), .Rst(rst), .MemToReg(mem_to_reg), .RegWrite(reg_write),
        .MemData(mem_data), .ALUResult(alu_result), .WriteRegister(write_reg),
        .ReadRegister1(read_reg1), .ReadRegister2(read_reg2),
        .ReadData1(rd1), .ReadData2(rd2), .WriteData(wdata),
        .DebugRegister(debug_reg), .DebugData(dbg), .WriteCount(wcount)
    );

    writeback_regfile #(.CNT_W(4)) dut_small (
        .Clk(clk), .Rst(rst), .MemToReg(mem_to_reg), .RegWrite(reg_write),
        .MemData(mem_data), .ALUResult(alu_result), .WriteRegister(write_reg),
        .ReadRegister1(read_reg1), .ReadRegister2(read_reg2),
        .ReadData1(rd1_s), .ReadData2(rd2_s), .WriteData(wdata_s),
        .DebugRegister(debug_reg), .DebugData(dbg_s), .WriteCount(wcount_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [4:0]  idx;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_counts(input string name);
        check({name, "_cnt"}, wcount, 32'(cnt_m));
        check({name, "_cnt4"}, {28'd0, wcount_s}, 32'(cnt_m % 16));
    endtask

    task automatic commit(input logic [4:0] wr, input logic [31:0] val);
        @(negedge clk);
        reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = val; write_reg = wr;
        @(posedge clk);
        #1 reg_write = 1'b0;
        if (wr != 5'd0) cnt_m++;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0,        32'h0000_1234, 5'd5,  5'd5,  32'h0000_1234, 32'h0000_1234, 1};
        vecs[1] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 2};
        vecs[2] = '{1'b1, 1'b0, 32'h0,        32'hFFFF_FFFF, 5'd0,  5'd0,  32'hFFFF_FFFF, 32'h0,         2};
        vecs[3] = '{1'b1, 1'b0, 32'h0,        32'h0000_0077, 5'd7,  5'd7,  32'h0000_0077, 32'h0000_0077, 3};
        vecs[4] = '{1'b0, 1'b0, 32'h0,        32'h0000_0055, 5'd7,  5'd7,  32'h0000_0055, 32'h0000_0077, 3};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0099, 32'h0000_0055, 5'd7,  5'd7,  32'h0000_0099, 32'h0000_0077, 3};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0011, 32'h0,         5'd9,  5'd9,  32'h0000_0011, 32'h0000_0011, 4};
        vecs[7] = '{1'b1, 1'b0, 32'h0,        32'h0000_CAFE, 5'd31, 5'd31, 32'h0000_CAFE, 32'h0000_CAFE, 5};

        rst = 1'b1; mem_to_reg = 1'b0; reg_write = 1'b0; mem_data = '0; alu_result = '0;
        write_reg = '0; read_reg1 = '0; read_reg2 = '0; debug_reg = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        read_reg1 = 5'd5; read_reg2 = 5'd31; debug_reg = 5'd5;
        #1;
        check("reset_rd1", rd1, 32'h0);
        check("reset_rd2", rd2, 32'h0);
        check("reset_dbg", dbg, 32'h0);
        check_counts("reset");

        // Table: mux, commit, $0 protection, write-disable
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            reg_write = vecs[i].rw; mem_to_reg = vecs[i].m2r;
            mem_data = vecs[i].mem; alu_result = vecs[i].alu; write_reg = vecs[i].wr;
            #1 check($sformatf("vec%0d_wdata", i), wdata, vecs[i].exp_wd);
            @(posedge clk);
            #1 reg_write = 1'b0;
            read_reg1 = vecs[i].idx; read_reg2 = vecs[i].idx;
            #1;
            check($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp_rd);
            check($sformatf("vec%0d_rd2", i), rd2, vecs[i].exp_rd);
            check($sformatf("vec%0d_cnt", i), wcount, 32'(vecs[i].exp_cnt));
        end
        cnt_m = 5;

        // Unknown data with RegWrite low must not reach storage
        @(negedge clk);
        reg_write = 1'b0; write_reg = 5'd5; mem_data = 'x; alu_result = 'x; mem_to_reg = 1'b1;
        @(posedge clk);
        #1 mem_data = '0; alu_result = '0; read_reg1 = 5'd5;
        #1 check("xdata_rd1", rd1, 32'hDEAD_BEEF);
        check_counts("xdata");

        // Same-cycle WB->ID hazard on reg9 (holds 0x11)
        @(negedge clk);
        reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'h22; write_reg = 5'd9;
        read_reg1 = 5'd0; read_reg2 = 5'd9;
        #1;
`ifdef WB_BYPASS_EN
        check("hazard_pre_rd2", rd2, 32'h22);
`else
        check("hazard_pre_rd2", rd2, 32'h11);
`endif
        check("hazard_pre_rd1_zero", rd1, 32'h0);
        @(posedge clk);
        #1 reg_write = 1'b0;
        cnt_m++;
        #1 check("hazard_post_rd2", rd2, 32'h22);
        read_reg1 = 5'd9;
        #1 check("hazard_post_rd1", rd1, 32'h22);
        check_counts("hazard");

        // Index-0 write with read of index 0 is never bypassed
        @(negedge clk);
        reg_write = 1'b1; alu_result = 32'hFFFF_0000; write_reg = 5'd0; read_reg1 = 5'd0; read_reg2 = 5'd0;
        #1 check("zero_pre_rd1", rd1, 32'h0);
        check("zero_pre_rd2", rd2, 32'h0);
        @(posedge clk);
        #1 reg_write = 1'b0;
        check_counts("zero_write");

        // Debug port: one-cycle latency, shows stored state rather than the bypass
        @(negedge clk);
        debug_reg = 5'd31;
        @(posedge clk);
        #1 check("dbg_r31", dbg, 32'h0000_CAFE);
        @(negedge clk);
        reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'h3C; write_reg = 5'd12; debug_reg = 5'd12;
        @(posedge clk);
        #1 reg_write = 1'b0;
        cnt_m++;
        check("dbg_r12_old", dbg, 32'h0);
        @(posedge clk);
        #1 check("dbg_r12_new", dbg, 32'h3C);
        check_counts("dbg");

        // Nine more commits bring the count to 16, wrapping the 4-bit counter
        for (int i = 1; i <= 9; i++) begin
            commit(5'(i), 32'h100 + 32'(i));
        end
        #1 check_counts("wrap");
        check("wrap_cnt4_zero", {28'd0, wcount_s}, 32'h0);
        read_reg1 = 5'd3;
        #1 check("wrap_r3", rd1, 32'h103);

        // Reset with a simultaneous write: write dropped, no bypass during reset
        @(negedge clk);
        rst = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b0; alu_result = 32'hAA; write_reg = 5'd3;
        read_reg1 = 5'd3; debug_reg = 5'd31;
        #1 check("rstwr_pre_rd1", rd1, 32'h103);
        @(posedge clk);
        #1 rst = 1'b0; reg_write = 1'b0;
        cnt_m = 0;
        check("rstwr_dbg", dbg, 32'h0);
        check_counts("rstwr");
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
            #1;
            check($sformatf("rst_rd1_%0d", i), rd1, 32'h0);
            check($sformatf("rst_rd2_%0d", 31 - i), rd2, 32'h0);
        end
        @(posedge clk);
        #1 check("rst_dbg_next", dbg, 32'h0);

        // Counting resumes from zero after reset
        commit(5'd3, 32'h5A);
        read_reg1 = 5'd3;
        #1 check("post_rst_r3", rd1, 32'h5A);
        check_counts("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Consumer end of the MEM/WB pipeline register.
- Takes the registered writeback controls and data, selects the writeback value, and commits it to a 32x32-bit MIPS general-purpose register file.
- Serves the two decode-stage read ports, plus one debug read port and a retired-write counter.
- Sits between the MEM/WB register outputs and the ID stage.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (2**ADDR_W registers)
- CNT_W, 32, width of the retired-write counter

Ports:
- Clk  in  1  rising-edge clock
- Rst  in  1  synchronous active-high reset
- MemToReg  in  1  1 = write MemData, 0 = write ALUResult (MEM/WB WB[0])
- RegWrite  in  1  writeback enable (MEM/WB WB[1])
- MemData  in  DATA_W  load data from MEM/WB
- ALUResult  in  DATA_W  ALU result from MEM/WB
- WriteRegister  in  ADDR_W  destination register index
- ReadRegister1  in  ADDR_W  ID read port 1 index
- ReadRegister2  in  ADDR_W  ID read port 2 index
- ReadData1  out  DATA_W  port 1 data
- ReadData2  out  DATA_W  port 2 data
- WriteData  out  DATA_W  selected writeback value (combinational, for forwarding unit/debug)
- DebugRegister  in  ADDR_W  debug read index
- DebugData  out  DATA_W  debug read data (registered)
- WriteCount  out  CNT_W  count of committed non-$0 writes

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high on Rst. Rst is sampled only at the rising edge of Clk.
- Reset action: on a Rst edge, all 32 registers, DebugData and WriteCount clear to 0.
- Reset priority: Rst wins over a simultaneous write. The pending write is dropped and not counted.
- Writeback mux: WriteData = MemToReg ? MemData : ALUResult. It is purely combinational and valid even when RegWrite=0.
- Commit: at a rising edge with Rst=0, RegWrite=1 and WriteRegister!=0, reg[WriteRegister] <= WriteData. One-cycle latency from MEM/WB output to storage.
- $0: register 0 is hardwired to 0. Writes to it are discarded and do not increment WriteCount. Every read of index 0 returns 0 on every port.
- Read ports 1 and 2: combinational, async index-to-data.
- Debug port: DebugData <= value at DebugRegister each edge. 1-cycle latency. It shows stored state, not the bypassed value.
- WriteCount: +1 on each committed non-$0 write. Wraps 2**CNT_W-1 -> 0 with no saturation.
- Simultaneous reads of the same index on both ports are legal; both ports return the same value.
- Writes with RegWrite=0 never alter state, regardless of WriteRegister, MemToReg or the data inputs.
- X on the data inputs with RegWrite=0 must not propagate into storage.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: internal write-through. If RegWrite=1, WriteRegister!=0 and WriteRegister==ReadRegisterN, then ReadDataN = WriteData in the same cycle. This closes the WB->ID hazard with no stall.
- Bypass priority: the bypass is suppressed while Rst=1, so ReadDataN returns the stored value during reset. An index-0 read is never bypassed.
- Not defined: ReadDataN always returns the stored value. The hazard unit must stall ID one extra cycle on a WB->ID dependency.
- The macro has no effect on DebugData or WriteCount.

Test Plan:
- Reset: pulse Rst 1 cycle after random writes -> all ReadData1/2 reads over indices 0..31 return 0, WriteCount=0, DebugData=0 next cycle.
- Mux/commit:
  - RegWrite=1, MemToReg=0, ALUResult=0x0000_1234, WriteRegister=5 -> after edge, ReadRegister1=5 gives 0x0000_1234, WriteCount=1.
  - Then MemToReg=1, MemData=0xDEAD_BEEF, WriteRegister=5 -> reg5=0xDEAD_BEEF, WriteCount=2.
- $0 protection: RegWrite=1, WriteRegister=0, ALUResult=0xFFFF_FFFF -> ReadData1 at index 0 = 0, WriteCount unchanged.
- Write disabled: RegWrite=0, WriteRegister=7, ALUResult=0x55 -> reg7 keeps its prior value. WriteData still shows 0x55.
- Same-cycle hazard: reg9=0x11, drive RegWrite=1, WriteRegister=9, ALUResult=0x22 with ReadRegister2=9 before the edge -> ReadData2=0x22 with WB_BYPASS_EN, 0x11 without. Both read 0x22 after the edge.
- Reset vs write and counter wrap:
  - Rst=1 together with a write to reg3=0xAA -> reg3=0 and WriteCount=0.
  - Separately, with CNT_W=4, 16 committed writes -> WriteCount wraps to 0.
